// File: rtl/amplitude_direction_pkg.sv
// Shared types for the amplitude direction finder: FSM state encoding,
// direction result codes and the unsigned absolute-difference helper.
package amplitude_direction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_HAVE_LEFT  = 2'b01,
        ST_HAVE_RIGHT = 2'b10,
        ST_DECIDE     = 2'b11
    } state_e;

    localparam logic [1:0] DIR_SILENT = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_RIGHT  = 2'b10;
    localparam logic [1:0] DIR_CENTER = 2'b11;

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/amplitude_direction_done_edge_detect.sv
// Rising-edge detector for a producer done level. The first clock after reset
// only loads the registered copy, so a level already high is not a new sample.
module done_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_done,
    output logic o_rise
);

    logic r_done;
    logic r_armed;

    // Registered copy of the done level plus the post-reset arming flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_done  <= i_done;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_done & ~r_done & r_armed;

endmodule

// File: rtl/amplitude_direction.sv
// Pairs left/right amplitude samples and reports which side is louder,
// discarding a lone sample when its partner does not arrive within TIMEOUT.
module amplitude_direction
    import amplitude_direction_pkg::*;
#(
    parameter logic [23:0] TIMEOUT  = 24'd1_000_000,
    parameter logic [15:0] DEADBAND = 16'd500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] left_amplitude,
    input  logic        left_done,
    input  logic [15:0] right_amplitude,
    input  logic        right_done,
    output logic [1:0]  direction,
    output logic [15:0] diff_mag,
    output logic        valid,
    output logic        timeout
);

    logic        w_left_rise;
    logic        w_right_rise;
    state_e      r_state;
    state_e      w_next_state;
    logic [23:0] r_timer;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic        w_waiting;
    logic        w_same;
    logic        w_partner;
    logic        w_expire_fire;
    logic        w_decide;
    logic [15:0] w_diff;
    logic [1:0]  w_dir;

    done_edge_detect u_left_edge (
        .clock  (clock),
        .reset  (reset),
        .i_done (left_done),
        .o_rise (w_left_rise)
    );

    done_edge_detect u_right_edge (
        .clock  (clock),
        .reset  (reset),
        .i_done (right_done),
        .o_rise (w_right_rise)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DECIDE reuses the IDLE rules so edges seen there are kept.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DECIDE: begin
                if (w_left_rise && w_right_rise) begin
                    w_next_state = ST_DECIDE;
                end else if (w_left_rise) begin
                    w_next_state = ST_HAVE_LEFT;
                end else if (w_right_rise) begin
                    w_next_state = ST_HAVE_RIGHT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HAVE_LEFT, ST_HAVE_RIGHT: begin
                if (w_partner) begin
                    w_next_state = ST_DECIDE;
                end else if (w_same) begin
                    w_next_state = r_state;
                end else if (w_expire_fire) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM output decode: partner/same-channel edges and timer expiry.
    always_comb begin
        w_waiting = (r_state == ST_HAVE_LEFT) || (r_state == ST_HAVE_RIGHT);
        w_partner = ((r_state == ST_HAVE_LEFT) && w_right_rise) ||
                    ((r_state == ST_HAVE_RIGHT) && w_left_rise);
        w_same    = ((r_state == ST_HAVE_LEFT) && w_left_rise) ||
                    ((r_state == ST_HAVE_RIGHT) && w_right_rise);
        w_decide  = (r_state == ST_DECIDE);
        if (w_waiting && !w_partner && !w_same && (r_timer == TIMEOUT - 24'd1)) begin
            w_expire_fire = 1'b1;
        end else begin
            w_expire_fire = 1'b0;
        end
    end

    // Wait timer: runs only while parked waiting, restarts on any other condition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= 24'd0;
        end else if (w_waiting && !w_partner && !w_same && !w_expire_fire) begin
            r_timer <= r_timer + 24'd1;
        end else begin
            r_timer <= 24'd0;
        end
    end

    // Amplitude captures, taken in the cycle of the edge; an expired lone sample is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_left  <= 16'd0;
            r_right <= 16'd0;
        end else begin
            if (w_left_rise) begin
                r_left <= left_amplitude;
            end else if (w_expire_fire && (r_state == ST_HAVE_LEFT)) begin
                r_left <= 16'd0;
            end
            if (w_right_rise) begin
                r_right <= right_amplitude;
            end else if (w_expire_fire && (r_state == ST_HAVE_RIGHT)) begin
                r_right <= 16'd0;
            end
        end
    end

    // Decision on the captured pair.
    always_comb begin
        w_diff = abs_diff(r_left, r_right);
        if ((r_left == 16'd0) && (r_right == 16'd0)) begin
            w_dir = DIR_SILENT;
        end else if (w_diff <= DEADBAND) begin
            w_dir = DIR_CENTER;
        end else if (r_left > r_right) begin
            w_dir = DIR_LEFT;
        end else begin
            w_dir = DIR_RIGHT;
        end
    end

    // Registered results and one-cycle pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            direction <= DIR_SILENT;
            diff_mag  <= 16'd0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= w_decide;
            timeout <= w_expire_fire;
            if (w_decide) begin
                direction <= w_dir;
                diff_mag  <= w_diff;
            end
        end
    end

endmodule

// File: tb/tb_amplitude_direction.sv
// Directed scenarios for amplitude_direction; expected results are queued at
// stimulus time and matched by a monitor whenever valid or timeout pulses.
module tb_amplitude_direction;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] left_amplitude = 16'd0;
    logic        left_done = 1'b0;
    logic [15:0] right_amplitude = 16'd0;
    logic        right_done = 1'b0;
    logic [1:0]  direction;
    logic [15:0] diff_mag;
    logic        valid;
    logic        timeout;

    typedef struct {
        bit          is_valid;
        logic [1:0]  dir;
        logic [15:0] diff;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   fin_req = 1'b0;

    amplitude_direction #(
        .TIMEOUT  (24'd100),
        .DEADBAND (16'd500)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .left_amplitude  (left_amplitude),
        .left_done       (left_done),
        .right_amplitude (right_amplitude),
        .right_done      (right_done),
        .direction       (direction),
        .diff_mag        (diff_mag),
        .valid           (valid),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic exp_valid(input logic [1:0] d, input logic [15:0] m, input int c);
        exp_t e;
        e.is_valid = 1'b1; e.dir = d; e.diff = m; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic exp_timeout(input int c);
        exp_t e;
        e.is_valid = 1'b0; e.dir = 2'b00; e.diff = 16'd0; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic pulse_left(input logic [15:0] a);
        left_amplitude = a; left_done = 1'b1;
        tick(1);
        left_done = 1'b0;
    endtask

    task automatic pulse_right(input logic [15:0] a);
        right_amplitude = a; right_done = 1'b1;
        tick(1);
        right_done = 1'b0;
    endtask

    // Both channels done together; decision expected two cycles later.
    task automatic pair(input logic [15:0] l, input logic [15:0] r,
                        input logic [1:0] d, input logic [15:0] m);
        exp_valid(d, m, cyc + 2);
        left_amplitude = l; right_amplitude = r;
        left_done = 1'b1; right_done = 1'b1;
        tick(1);
        left_done = 1'b0; right_done = 1'b0;
        tick(5);
    endtask

    // Monitor: reset-state checks, scoreboard matching, and end-of-run drain.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            n_vec++;
            if (direction !== 2'b00 || diff_mag !== 16'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got dir=%b diff=%0d valid=%b timeout=%b, want all zero",
                         direction, diff_mag, valid, timeout);
            end
        end else if (valid || timeout) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: valid=%b timeout=%b dir=%b diff=%0d at cycle %0d, nothing expected",
                         valid, timeout, direction, diff_mag, cyc);
            end else begin
                e = sb_q.pop_front();
                if (valid !== e.is_valid || timeout !== !e.is_valid || cyc != e.cyc ||
                    (e.is_valid && (direction !== e.dir || diff_mag !== e.diff))) begin
                    n_err++;
                    $display("FAIL %s: got valid=%b timeout=%b dir=%b diff=%0d cyc=%0d, want %s dir=%b diff=%0d cyc=%0d",
                             e.is_valid ? "decision" : "timeout", valid, timeout, direction, diff_mag, cyc,
                             e.is_valid ? "valid" : "timeout", e.dir, e.diff, e.cyc);
                end
            end
        end
        if (fin_req) begin
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_out: got nothing, want %s dir=%b diff=%0d at cycle %0d",
                         e.is_valid ? "valid" : "timeout", e.dir, e.diff, e.cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        int c;
        tick(3);
        reset = 1'b1;
        tick(3);

        // Scenario 1: left then right 10 cycles later.
        pulse_left(16'd6000);
        tick(9);
        exp_valid(2'b10, 16'd3000, cyc + 2);
        pulse_right(16'd9000);
        tick(5);

        // Scenarios 2 and 3 plus deadband and extreme boundaries.
        pair(16'd7000, 16'd6800, 2'b11, 16'd200);
        pair(16'd0,    16'd0,    2'b00, 16'd0);
        pair(16'd5000, 16'd5500, 2'b11, 16'd500);
        pair(16'd5000, 16'd4499, 2'b01, 16'd501);
        pair(16'd0,    16'd1,    2'b11, 16'd1);
        pair(16'd65535, 16'd0,   2'b01, 16'd65535);

        // Scenario 4: lone left times out, then right waits for a left partner.
        c = cyc;
        exp_timeout(c + 101);
        pulse_left(16'd5000);
        tick(109);
        pulse_right(16'd5200);
        tick(8);
        exp_valid(2'b11, 16'd100, cyc + 2);
        pulse_left(16'd5100);
        tick(5);

        // Left recapture overwrites the earlier left amplitude.
        pulse_left(16'd1000);
        tick(4);
        pulse_left(16'd8000);
        tick(4);
        exp_valid(2'b01, 16'd6000, cyc + 2);
        pulse_right(16'd2000);
        tick(5);

        // Left recapture restarts the timer.
        pulse_left(16'd3000);
        tick(49);
        exp_timeout(cyc + 101);
        pulse_left(16'd3000);
        tick(110);

        // Partner edge in the expiry cycle wins over the timeout.
        c = cyc;
        pulse_left(16'd2000);
        tick(c + 100 - cyc);
        exp_valid(2'b10, 16'd5000, cyc + 2);
        pulse_right(16'd7000);
        tick(5);

        // Lone right also times out.
        exp_timeout(cyc + 101);
        pulse_right(16'd100);
        tick(110);

        // Scenario 5: held left done gives one sample; left edge in DECIDE is kept.
        left_amplitude = 16'd3000;
        left_done = 1'b1;
        tick(50);
        left_done = 1'b0;
        exp_valid(2'b10, 16'd1000, cyc + 2);
        right_amplitude = 16'd4000;
        right_done = 1'b1;
        tick(1);
        right_done = 1'b0;
        left_amplitude = 16'd9000;
        left_done = 1'b1;
        tick(1);
        left_done = 1'b0;
        tick(7);
        exp_valid(2'b11, 16'd200, cyc + 2);
        pulse_right(16'd8800);
        tick(5);

        // Scenario 6: reset while parked in HAVE_LEFT with left done held high.
        left_amplitude = 16'd1234;
        left_done = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(10);
        pulse_right(16'd4000);
        tick(5);
        left_done = 1'b0;
        tick(2);
        exp_valid(2'b11, 16'd100, cyc + 2);
        left_amplitude = 16'd3900;
        left_done = 1'b1;
        tick(1);
        left_done = 1'b0;
        tick(6);

        fin_req = 1'b1;
        tick(3);
        $display("FAIL monitor_stall: summary not reached within 3 cycles of end of stimulus");
        $fatal(1);
    end

endmodule

// File: doc/amplitude_direction.md
AMPLITUDE_DIRECTION -- requirements
Module: amplitude_direction

Interface
REQ-001 Parameter TIMEOUT, default 24'd1_000_000: cycles to wait for the partner channel's update before discarding a lone sample.
REQ-002 Parameter DEADBAND, default 16'd500: maximum |left-right| difference still reported as center.
REQ-003 clock  input  1  system clock; the single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 left_amplitude  input  16  unsigned left-mic integrated amplitude, valid while left_done is high.
REQ-006 left_done  input  1  left producer done level, held high for one or more cycles per new amplitude.
REQ-007 right_amplitude  input  16  unsigned right-mic integrated amplitude.
REQ-008 right_done  input  1  right producer done level, same semantics as left_done.
REQ-009 direction  output  2  result code: 00 silent, 01 left, 10 right, 11 center.
REQ-010 diff_mag  output  16  |left-right| of the last decided pair.
REQ-011 valid  output  1  one-cycle pulse when direction and diff_mag update.
REQ-012 timeout  output  1  one-cycle pulse when a lone sample is discarded.

Function
REQ-013 A new sample is the rising edge of a done input, detected against a registered copy of that input; a done input held high yields exactly one sample.
REQ-014 On a rising edge, the matching amplitude is captured in that same cycle.
REQ-015 The FSM states are IDLE, HAVE_LEFT, HAVE_RIGHT, and DECIDE.
REQ-016 IDLE transitions: left edge only -> HAVE_LEFT; right edge only -> HAVE_RIGHT; both in the same cycle -> DECIDE.
REQ-017 HAVE_LEFT transitions: right edge -> DECIDE; another left edge -> overwrite the left capture, clear the timer, and stay in HAVE_LEFT; if both edges arrive together, capture both and go to DECIDE.
REQ-018 HAVE_RIGHT mirrors HAVE_LEFT with the channels swapped.
REQ-019 In HAVE_LEFT and HAVE_RIGHT, a 24-bit timer counts from 0 each cycle; when it reaches TIMEOUT-1 with no partner edge, the FSM returns to IDLE, pulses timeout next cycle, and discards the lone capture.
REQ-020 A partner edge in the same cycle as the timer expiry takes priority; no timeout pulse is produced.
REQ-021 DECIDE lasts one cycle and registers the outputs, so valid is high in cycle N+2 when the pair-completing edge is seen in cycle N.
REQ-022 Decision rules: both captures equal 0 -> 00; otherwise diff = |L-R| as 16-bit unsigned; diff <= DEADBAND -> 11; else L>R -> 01, else 10.
REQ-023 diff_mag is updated on every decision, including silent decisions.
REQ-024 Edges seen during DECIDE are not lost: left only -> HAVE_LEFT, right only -> HAVE_RIGHT, both -> DECIDE again, none -> IDLE.
REQ-025 direction and diff_mag hold their values between valid pulses; valid and timeout are never high in the same cycle.

Reset
REQ-026 While reset is low: state=IDLE; timer, captures, and registered done copies =0; direction=00, diff_mag=0, valid=0, timeout=0.
REQ-027 A reset asserted mid-pair discards the pending captures.
REQ-028 After reset deasserts, a done input that is already high is not treated as an edge; the registered copies reload from the inputs during the first clock after reset.

Structure
REQ-029 A shared package holds the FSM state encodings and the direction codes DIR_SILENT, DIR_LEFT, DIR_RIGHT, and DIR_CENTER.
REQ-030 One sub-module, done_edge_detect, is instantiated per channel; it holds the registered done copy and outputs a one-cycle rise pulse.
REQ-031 The difference and decision logic is combinational, feeding the DECIDE output registers; no sub-module is used for it.

Verification
REQ-032 Scenario 1: left=6000 done, then right=9000 done 10 cycles later -> valid once, 2 cycles after the right edge, with direction=10 and diff_mag=3000.
REQ-033 Scenario 2: left=7000 and right=6800, both done in the same cycle -> valid 2 cycles later, direction=11, diff_mag=200.
REQ-034 Scenario 3: left=0 and right=0 -> direction=00, diff_mag=0, valid pulse.
REQ-035 Scenario 4: with TIMEOUT=100, left=5000 done and no right -> timeout pulse after 100 cycles, no valid, state IDLE; a subsequent right=5200 goes to HAVE_RIGHT.
REQ-036 Scenario 5: left done held high for 50 cycles, then right=4000 -> exactly one valid; a left edge during DECIDE is captured and leads to HAVE_LEFT.
REQ-037 Scenario 6: reset low while in HAVE_LEFT -> all outputs 0 immediately; with left_done high at release, no sample is taken until left_done falls and rises again.
